// File: rtl/roic_readout_sequencer.sv
// Line readout sequencer: walks the enabled ROIC channels in index order, requests
// A/B word pairs from each one and streams them out under a valid/ready handshake.
module roic_readout_sequencer #(
    parameter int NUM_CH     = 12,
    parameter int DATA_WIDTH = 24,
    parameter int TIMEOUT    = 64
) (
    input  logic                         data_read_clk,
    input  logic                         deser_reset,
    input  logic                         line_start,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [9:0]                   words_per_ch,
    input  logic                         err_clear,
    input  logic [NUM_CH-1:0]            valid_read_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] reordered_data_a,
    input  logic [NUM_CH*DATA_WIDTH-1:0] reordered_data_b,
    input  logic [NUM_CH-1:0]            reordered_valid,
    output logic [NUM_CH-1:0]            data_read_req,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_ch,
    output logic                         out_last,
    output logic                         busy,
    output logic                         line_done,
    output logic [NUM_CH-1:0]            timeout_err
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, SEL, WAIT_EN, WAIT_DATA, EMIT_A, EMIT_B, DONE} state_t;

    state_t                  state;
    logic [NUM_CH-1:0]       pending;
    logic [9:0]              wpc;
    logic [9:0]              pair_cnt;
    logic [3:0]              ch;
    logic                    last_ch;
    logic [TW-1:0]           tmo_cnt;
    logic [DATA_WIDTH-1:0]   hold_b;

    logic                    sel_found;
    logic [3:0]              sel_idx;
    logic [NUM_CH-1:0]       sel_onehot;
    logic [NUM_CH-1:0]       ch_onehot;
    logic                    cur_en;
    logic                    cur_valid;
    logic [DATA_WIDTH-1:0]   cur_a;
    logic [DATA_WIDTH-1:0]   cur_b;
    logic                    tmo_hit;
    logic                    final_pair;

    // Lowest-index channel still waiting to be served this line.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = 4'd0;
        sel_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sel_found  = pending[i] ? 1'b1 : sel_found;
            sel_idx    = pending[i] ? 4'(i) : sel_idx;
            sel_onehot = pending[i] ? (NUM_CH'(1) << i) : sel_onehot;
        end
    end

    // Per-channel inputs of the channel currently being served.
    always_comb begin
        cur_en    = 1'b0;
        cur_valid = 1'b0;
        cur_a     = '0;
        cur_b     = '0;
        ch_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_en       = (ch == 4'(i)) ? valid_read_enable[i] : cur_en;
            cur_valid    = (ch == 4'(i)) ? reordered_valid[i] : cur_valid;
            cur_a        = (ch == 4'(i)) ? reordered_data_a[i*DATA_WIDTH +: DATA_WIDTH] : cur_a;
            cur_b        = (ch == 4'(i)) ? reordered_data_b[i*DATA_WIDTH +: DATA_WIDTH] : cur_b;
            ch_onehot[i] = (ch == 4'(i));
        end
    end

    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    // Widened compare so a 1023-pair line can never alias through a wrap.
    assign final_pair = ({1'b0, pair_cnt} + 11'd1) >= {1'b0, wpc};

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge data_read_clk) begin
        if (deser_reset) begin
            state         <= IDLE;
            pending       <= '0;
            wpc           <= 10'd0;
            pair_cnt      <= 10'd0;
            ch            <= 4'd0;
            last_ch       <= 1'b0;
            tmo_cnt       <= '0;
            hold_b        <= '0;
            data_read_req <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_ch        <= 4'd0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            line_done     <= 1'b0;
            timeout_err   <= '0;
        end else begin
            data_read_req <= '0;
            line_done     <= 1'b0;
            if (err_clear) begin
                timeout_err <= '0;
            end
            case (state)
                IDLE: begin
                    if (line_start) begin
                        pending <= (words_per_ch == 10'd0) ? '0 : ch_enable;
                        wpc     <= words_per_ch;
                        busy    <= 1'b1;
                        state   <= SEL;
                    end
                end
                SEL: begin
                    pair_cnt <= 10'd0;
                    if (sel_found) begin
                        ch      <= sel_idx;
                        last_ch <= ((pending & ~sel_onehot) == '0);
                        tmo_cnt <= '0;
                        state   <= WAIT_EN;
                    end else begin
                        busy      <= 1'b0;
                        line_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                WAIT_EN, WAIT_DATA: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (tmo_hit) begin
                        // A timeout raised here overrides a simultaneous clear.
                        timeout_err <= (err_clear ? '0 : timeout_err) | ch_onehot;
                        pending     <= pending & ~ch_onehot;
                        state       <= SEL;
                    end else if (state == WAIT_EN && cur_en) begin
                        data_read_req <= ch_onehot;
                        state         <= WAIT_DATA;
                    end else if (state == WAIT_DATA && cur_valid) begin
                        out_data  <= cur_a;
                        hold_b    <= cur_b;
                        out_ch    <= ch;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= EMIT_A;
                    end
                end
                EMIT_A: begin
                    if (out_ready) begin
                        out_data <= hold_b;
                        out_last <= last_ch && final_pair;
                        state    <= EMIT_B;
                    end
                end
                EMIT_B: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (final_pair) begin
                            pending <= pending & ~ch_onehot;
                            state   <= SEL;
                        end else begin
                            pair_cnt <= pair_cnt + 10'd1;
                            tmo_cnt  <= '0;
                            state    <= WAIT_EN;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_roic_readout_sequencer.sv
// Directed bench: a channel responder answers each request after three cycles and a
// monitor records every transferred word for comparison against hand-built sequences.
`timescale 1ns/1ps
module tb_roic_readout_sequencer;
    localparam int NUM_CH  = 12;
    localparam int DW      = 24;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 deser_reset;
    logic                 line_start;
    logic [NUM_CH-1:0]    ch_enable;
    logic [9:0]           words_per_ch;
    logic                 err_clear;
    logic [NUM_CH-1:0]    valid_read_enable;
    logic [NUM_CH*DW-1:0] reordered_data_a;
    logic [NUM_CH*DW-1:0] reordered_data_b;
    logic [NUM_CH-1:0]    reordered_valid;
    logic [NUM_CH-1:0]    data_read_req;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           out_ch;
    logic                 out_last;
    logic                 busy;
    logic                 line_done;
    logic [NUM_CH-1:0]    timeout_err;

    always #2.5 clk = ~clk;

    roic_readout_sequencer #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .data_read_clk(clk), .deser_reset(deser_reset), .line_start(line_start),
        .ch_enable(ch_enable), .words_per_ch(words_per_ch), .err_clear(err_clear),
        .valid_read_enable(valid_read_enable), .reordered_data_a(reordered_data_a),
        .reordered_data_b(reordered_data_b), .reordered_valid(reordered_valid),
        .data_read_req(data_read_req), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_last(out_last), .busy(busy),
        .line_done(line_done), .timeout_err(timeout_err)
    );

    logic [63:0] outs_all;
    assign outs_all = {8'd0, data_read_req, out_valid, out_last, out_data, out_ch,
                       busy, line_done, timeout_err};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_a(input logic [7:0] t, input int c, input int s);
        return {t, 4'(c), 12'(s)};
    endfunction

    function automatic logic [DW-1:0] word_b(input logic [7:0] t, input int c, input int s);
        return {~t, 4'(c), 12'(s)};
    endfunction

    function automatic logic [63:0] pack(input logic last, input int c, input logic [DW-1:0] d);
        return {35'd0, last, 4'(c), d};
    endfunction

    // Responder: answers a request 3 cycles later; optional stray pulse on a neighbour channel.
    logic [7:0]  tag = 8'h00;
    logic [7:0]  seen_tag = 8'h00;
    logic [NUM_CH-1:0] mute = '0;
    bit          spur = 1'b0;
    int          seq = 0;
    int          rv_cnt = 0;
    int          rv_ch = 0;
    int          rv_seq = 0;

    always @(negedge clk) begin
        reordered_valid = '0;
        if (tag != seen_tag) begin
            seq = 0;
            seen_tag = tag;
        end
        if (deser_reset) begin
            rv_cnt = 0;
        end else begin
            if (rv_cnt != 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        reordered_data_a[i*DW +: DW] = word_a(tag, i, rv_seq);
                        reordered_data_b[i*DW +: DW] = word_b(tag, i, rv_seq);
                    end
                    reordered_valid[rv_ch] = 1'b1;
                end else if (rv_cnt == 1 && spur) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        reordered_data_a[i*DW +: DW] = {8'hDE, 4'(i), 12'hBAD};
                        reordered_data_b[i*DW +: DW] = {8'hBE, 4'(i), 12'hEEF};
                    end
                    reordered_valid[(rv_ch + 1) % NUM_CH] = 1'b1;
                end
            end
            if (data_read_req != '0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (data_read_req[i]) rv_ch = i;
                end
                rv_seq = seq;
                seq++;
                if (!mute[rv_ch]) rv_cnt = 3;
            end
        end
    end

    // Monitor: word capture, event counters and protocol flags.
    logic [63:0] wq[$];
    int          ld_count = 0;
    int          req_count = 0;
    int          ov_count = 0;
    int          stall_cycles = 0;
    int          stall_bad = 0;
    int          req_bad = 0;
    bit          stall_prev = 1'b0;
    logic [63:0] hold_word = '0;

    always @(negedge clk) begin
        if (stall_prev && ({out_valid, out_last, out_ch, out_data} !== {1'b1, hold_word[28:0]}))
            stall_bad++;
        if (out_valid === 1'b1) begin
            ov_count++;
            if (out_ready) wq.push_back(pack(out_last, int'(out_ch), out_data));
            else stall_cycles++;
        end
        stall_prev = (out_valid === 1'b1) && !out_ready;
        hold_word  = pack(out_last, int'(out_ch), out_data);
        if (line_done === 1'b1) ld_count++;
        if (data_read_req !== '0 && data_read_req !== 'x) begin
            req_count++;
            if (!$onehot(data_read_req) || out_valid !== 1'b0) req_bad++;
        end
    end

    task automatic run_line(input logic [7:0] t, input logic [11:0] m, input logic [9:0] w,
                            input bit toggle);
        int ld0;
        tag = t;
        ch_enable = m;
        words_per_ch = w;
        out_ready = 1'b1;
        ld0 = ld_count;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (ld_count != ld0) break;
            if (toggle) out_ready = ~out_ready;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check_eq($sformatf("line_done_%0h", t), 64'(ld_count - ld0), 64'd1);
    endtask

    task automatic check_words(input logic [7:0] t, input logic [11:0] m, input int w,
                               input int ws);
        int total;
        int s;
        int k;
        total = $countones(m) * w * 2;
        check_eq($sformatf("word_count_%0h", t), 64'(wq.size() - ws), 64'(total));
        s = 0;
        k = ws;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                for (int p = 0; p < w; p++) begin
                    if (k < wq.size()) check_eq("word_a", wq[k], pack(1'b0, c, word_a(t, c, s)));
                    k++;
                    if (k < wq.size())
                        check_eq("word_b", wq[k], pack((k - ws + 1) == total, c, word_b(t, c, s)));
                    k++;
                    s++;
                end
            end
        end
    endtask

    initial begin
        int ws;
        int r0;
        int ld0;
        int ov0;
        int st0;
        int hit;
        deser_reset       = 1'b1;
        line_start        = 1'b0;
        ch_enable         = '0;
        words_per_ch      = 10'd0;
        err_clear         = 1'b0;
        valid_read_enable = '1;
        reordered_data_a  = '0;
        reordered_data_b  = '0;
        reordered_valid   = '0;
        out_ready         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", outs_all, 64'd0);
        deser_reset = 1'b0;
        @(posedge clk); #1;

        // Two channels, two pairs each, free-flowing sink, stray valids on neighbours.
        spur = 1'b1;
        ws = wq.size();
        r0 = req_count;
        run_line(8'h11, 12'h005, 10'd2, 1'b0);
        check_words(8'h11, 12'h005, 2, ws);
        check_eq("t1_reqs", 64'(req_count - r0), 64'd4);
        check_eq("t1_busy", 64'(busy), 64'd0);
        check_eq("t1_tmo", 64'(timeout_err), 64'd0);

        // Same line with the sink stalling every other cycle.
        ws = wq.size();
        st0 = stall_cycles;
        run_line(8'h22, 12'h005, 10'd2, 1'b1);
        check_words(8'h22, 12'h005, 2, ws);
        check_eq("t2_stalls_seen", 64'(stall_cycles > st0), 64'd1);
        check_eq("t2_stall_hold", 64'(stall_bad), 64'd0);
        spur = 1'b0;

        // Channel 1 never answers: timeout after 64 cycles in the wait states.
        tag = 8'h33;
        mute = 12'h002;
        ch_enable = 12'h002;
        words_per_ch = 10'd3;
        ws = wq.size();
        r0 = req_count;
        ld0 = ld_count;
        line_start = 1'b1;
        hit = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            line_start = 1'b0;
            if (timeout_err != '0) begin
                hit = k;
                break;
            end
        end
        check_eq("tmo_cycles", 64'(hit), 64'd66);
        check_eq("tmo_err", 64'(timeout_err), 64'h002);
        repeat (4) @(posedge clk);
        #1;
        check_eq("tmo_line_done", 64'(ld_count - ld0), 64'd1);
        check_eq("tmo_reqs", 64'(req_count - r0), 64'd1);
        check_eq("tmo_words", 64'(wq.size() - ws), 64'd0);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check_eq("tmo_clear", 64'(timeout_err), 64'd0);
        mute = '0;

        // Empty mask: line_done two cycles after line_start, restart while busy ignored.
        tag = 8'h44;
        ch_enable = 12'h000;
        words_per_ch = 10'd2;
        r0 = req_count;
        ld0 = ld_count;
        ov0 = ov_count;
        line_start = 1'b1;
        @(posedge clk); #1;
        check_eq("m0_busy", 64'(busy), 64'd1);
        check_eq("m0_done_early", 64'(line_done), 64'd0);
        @(posedge clk); #1;
        line_start = 1'b0;
        check_eq("m0_done", 64'(line_done), 64'd1);
        check_eq("m0_busy_low", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_eq("m0_done_pulse", 64'(line_done), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("m0_done_count", 64'(ld_count - ld0), 64'd1);
        check_eq("m0_busy_idle", 64'(busy), 64'd0);
        check_eq("m0_reqs", 64'(req_count - r0), 64'd0);
        check_eq("m0_valid", 64'(ov_count - ov0), 64'd0);

        // Zero pairs per channel behaves like an empty mask.
        r0 = req_count;
        ov0 = ov_count;
        run_line(8'h45, 12'h005, 10'd0, 1'b0);
        check_eq("w0_reqs", 64'(req_count - r0), 64'd0);
        check_eq("w0_valid", 64'(ov_count - ov0), 64'd0);

        // Reset in the middle of channel 5, then a clean full-width line.
        tag = 8'h55;
        ch_enable = 12'hFFF;
        words_per_ch = 10'd1;
        ld0 = ld_count;
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
        hit = 0;
        for (int k = 0; k < 300; k++) begin
            if (data_read_req[5]) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("rst_reach_ch5", 64'(hit), 64'd1);
        deser_reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_outs", outs_all, 64'd0);
        deser_reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_no_done", 64'(ld_count - ld0), 64'd0);
        ws = wq.size();
        run_line(8'h56, 12'hFFF, 10'd1, 1'b0);
        check_words(8'h56, 12'hFFF, 1, ws);

        check_eq("req_protocol", 64'(req_bad), 64'd0);
        check_eq("stall_hold_all", 64'(stall_bad), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
